sdm_tx_mc: RTL and testbench

Multi-channel sigma-delta transmitter, the parametrised successor of the single-channel sdm_tx.
- Frames of NCH signed samples enter a shared FIFO via toggle handshake in the clk domain.
- Each channel runs an error-feedback modulator clocked by synchronised rising edges of the slow fclk.
- Emits one 1-bit stream per channel on tx[NCH-1:0]; pairs with per-channel sdm_rx instances on the link side.

---
 rtl/sdm_mc_pkg.sv | 32 +++
 rtl/sdm_mod_ch.sv | 92 +++++++++
 rtl/sdm_tx_mc.sv | 155 +++++++++++++++
 tb/tb_sdm_tx_mc.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sdm_mc_pkg.sv
// sdm_mc_pkg: shared types and sizing helpers for the multi-channel
// sigma-delta transmitter (sdm_tx_mc) and its per-channel modulator.
//   state_t  : transmitter FSM states (encoding 3 is illegal, decodes to IDLE)
//   acc_w    : first-order accumulator width for a sample MSB of dmsb
//   acc2_w   : second-order integrator width (SDM_ORDER2_EN build)
//   fs_val   : full-scale magnitude 2^dmsb
//   ch_lsb   : LSB position of channel k inside a packed frame
package sdm_mc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   function automatic int acc_w(input int dmsb);
      return dmsb + 3;
   endfunction

   function automatic int acc2_w(input int dmsb);
      return dmsb + 5;
   endfunction

   function automatic int fs_val(input int dmsb);
      return 1 << dmsb;
   endfunction

   function automatic int ch_lsb(input int k, input int dmsb);
      return k * (dmsb + 1);
   endfunction

endpackage

// File: rtl/sdm_mod_ch.sv
// sdm_mod_ch: one channel's error-feedback sigma-delta modulator.
// Updates once per tick; clr synchronously zeroes the loop state and tx.
// Macro SDM_ORDER2_EN selects a saturating second-order CIFB loop;
// otherwise a first-order loop with a single accumulator is built.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   clr       : synchronous clear of integrators and tx (priority over tick)
//   tick      : one-cycle update strobe
//   x         : signed sample, legal range -FS..FS-1
//   tx        : registered 1-bit output stream
module sdm_mod_ch
   import sdm_mc_pkg::*;
#(
   parameter int DMSB = 3
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              clr,
   input  logic              tick,
   input  logic signed [DMSB:0] x,
   output logic              tx
);

`ifdef SDM_ORDER2_EN
   localparam int W  = acc2_w(DMSB);
   localparam int WW = W + 2;
   localparam logic signed [WW-1:0] FSW  = WW'(fs_val(DMSB));
   localparam logic signed [WW-1:0] MAXV = WW'((1 << (W - 1)) - 1);
   localparam logic signed [WW-1:0] MINV = -MAXV - WW'(1);

   logic signed [W-1:0]  a1, a2;
   logic signed [WW-1:0] fb, s1, s2;
   logic                 y;

   function automatic logic signed [W-1:0] sat(input logic signed [WW-1:0] v);
      if (v > MAXV)      return MAXV[W-1:0];
      else if (v < MINV) return MINV[W-1:0];
      else               return v[W-1:0];
   endfunction

   // Sums formed two bits wider than the integrators so saturation sees the true value.
   always_comb begin
      y  = ~a2[W-1];
      fb = y ? FSW : -FSW;
      s1 = WW'(a1) + WW'(x) - fb;
      s2 = WW'(a2) + WW'(a1) - fb;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         a1 <= '0;
         a2 <= '0;
         tx <= 1'b0;
      end else if (clr) begin
         a1 <= '0;
         a2 <= '0;
         tx <= 1'b0;
      end else if (tick) begin
         a1 <= sat(s1);
         a2 <= sat(s2);
         tx <= y;
      end
   end
`else
   localparam int W = acc_w(DMSB);
   localparam logic signed [W-1:0] FSW = W'(fs_val(DMSB));

   // |acc| stays within 2*FS, so DMSB+3 bits never overflow.
   logic signed [W-1:0] acc, fb, nxt;
   logic                y;

   always_comb begin
      y   = ~acc[W-1];
      fb  = y ? FSW : -FSW;
      nxt = acc + W'(x) - fb;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc <= '0;
         tx  <= 1'b0;
      end else if (clr) begin
         acc <= '0;
         tx  <= 1'b0;
      end else if (tick) begin
         acc <= nxt;
         tx  <= y;
      end
   end
`endif

endmodule

// File: rtl/sdm_tx_mc.sv
// sdm_tx_mc: multi-channel sigma-delta transmitter.
// Frames of NCH signed samples are written into a shared FIFO by push
// toggles; an IDLE/LOAD/RUN FSM pops one frame per OSR fclk ticks into
// hold registers driving NCH modulators (sdm_mod_ch).
// Optional macro SDM_ORDER2_EN: second-order modulators (inside sdm_mod_ch).
// Ports:
//   clk, rstn       : clock, asynchronous active-low reset
//   setn            : synchronous run enable (low -> IDLE, modulators cleared)
//   fclk            : modulator rate clock (async, period >= 4 clk)
//   push, clear     : toggle strobes (write frame / flush FIFO)
//   wdata           : frame, channel k at [k*(DMSB+1) +: DMSB+1]
//   empty, full     : FIFO status
//   underrun        : sticky, frame boundary with FIFO empty
//   overrun         : sticky, push while full
//   xst, nst        : current / next FSM state
//   cst             : oversampling tick counter
//   tx              : per-channel bitstreams
module sdm_tx_mc
   import sdm_mc_pkg::*;
#(
   parameter int DMSB = 3,
   parameter int NCH  = 2,
   parameter int AMSB = 1,
   parameter int CMSB = 1
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     setn,
   input  logic                     fclk,
   input  logic                     push,
   input  logic                     clear,
   input  logic [NCH*(DMSB+1)-1:0]  wdata,
   output logic                     empty,
   output logic                     full,
   output logic                     underrun,
   output logic                     overrun,
   output logic [1:0]               xst,
   output logic [1:0]               nst,
   output logic [CMSB:0]            cst,
   output logic [NCH-1:0]           tx
);

   localparam int DW    = NCH * (DMSB + 1);
   localparam int DEPTH = 1 << (AMSB + 1);
   localparam logic [CMSB:0] CST_LAST = '1;

   // [1:0] synchroniser, [2] edge register
   logic [2:0] push_s, clear_s, fclk_s;
   logic       push_ev, clr_ev, tick;

   logic [DW-1:0]         mem [DEPTH];
   logic [AMSB+1:0]       wr_ptr, rd_ptr, wr_n, rd_n;
   logic                  push_ok, pop, wrap_tick, mod_tick;
   state_t                state, state_n;
   logic signed [DMSB:0]  hold [NCH];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         push_s  <= '0;
         clear_s <= '0;
         fclk_s  <= '0;
      end else begin
         push_s  <= {push_s[1:0], push};
         clear_s <= {clear_s[1:0], clear};
         fclk_s  <= {fclk_s[1:0], fclk};
      end
   end

   assign push_ev = push_s[1] ^ push_s[2];
   assign clr_ev  = clear_s[1] ^ clear_s[2];
   assign tick    = fclk_s[1] & ~fclk_s[2];

   // Clear wins over push and pop; empty/full are derived from the next
   // pointers so they are consistent with the pointers they are stored with.
   always_comb begin
      wrap_tick = setn && (state == RUN) && tick && (cst == CST_LAST);
      mod_tick  = setn && (state == RUN) && tick;
      pop       = 1'b0;
      if (setn && !clr_ev && !empty)
         pop = (state == LOAD) || wrap_tick;
      push_ok = push_ev && !full && !clr_ev;
      wr_n    = wr_ptr + (AMSB+2)'(push_ok);
      rd_n    = rd_ptr + (AMSB+2)'(pop);
      if (clr_ev) begin
         wr_n = wr_ptr;
         rd_n = wr_ptr;
      end
   end

   always_comb begin
      state_n = IDLE;
      if (setn) begin
         case (state)
            IDLE:    state_n = LOAD;
            LOAD:    state_n = pop ? RUN : LOAD;
            RUN:     state_n = RUN;
            default: state_n = IDLE;
         endcase
      end
   end

   assign xst = state;
   assign nst = rstn ? state_n : IDLE;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         cst      <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         empty    <= 1'b1;
         full     <= 1'b0;
         underrun <= 1'b0;
         overrun  <= 1'b0;
         for (int unsigned k = 0; k < NCH; k++) hold[k] <= '0;
      end else begin
         state  <= state_n;
         wr_ptr <= wr_n;
         rd_ptr <= rd_n;
         empty  <= (wr_n == rd_n);
         full   <= (wr_n[AMSB:0] == rd_n[AMSB:0]) && (wr_n[AMSB+1] != rd_n[AMSB+1]);
         if (clr_ev) begin
            underrun <= 1'b0;
            overrun  <= 1'b0;
         end else begin
            if (push_ev && full)    overrun  <= 1'b1;
            if (wrap_tick && empty) underrun <= 1'b1;
         end
         if (!setn)
            cst <= '0;
         else if (mod_tick)
            cst <= cst + (CMSB+1)'(1);
         // A tick in the same cycle still sees the old held sample.
         if (pop)
            for (int unsigned k = 0; k < NCH; k++)
               hold[k] <= mem[rd_ptr[AMSB:0]][ch_lsb(k, DMSB) +: DMSB+1];
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AMSB:0]] <= wdata;
   end

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      sdm_mod_ch #(.DMSB(DMSB)) u_ch (
         .clk  (clk),
         .rstn (rstn),
         .clr  (!setn),
         .tick (mod_tick),
         .x    (hold[k]),
         .tx   (tx[k])
      );
   end

endmodule

// File: tb/tb_sdm_tx_mc.sv
// tb_sdm_tx_mc: directed self-checking bench for sdm_tx_mc (DMSB=3, NCH=2,
// AMSB=1, CMSB=1 -> FS=8, FIFO depth 4, OSR 4). Expected tx sequences are
// hand-derived first-order modulator traces starting from acc=0.
module tb_sdm_tx_mc;

   localparam int DMSB = 3;
   localparam int NCH  = 2;
   localparam int AMSB = 1;
   localparam int CMSB = 1;

   logic                    clk, rstn, setn, fclk, push, clear;
   logic [NCH*(DMSB+1)-1:0] wdata;
   logic                    empty, full, underrun, overrun;
   logic [1:0]              xst, nst;
   logic [CMSB:0]           cst;
   logic [NCH-1:0]          tx;

   int total = 0;
   int bad   = 0;
   int ones0, ones1;

   sdm_tx_mc #(.DMSB(DMSB), .NCH(NCH), .AMSB(AMSB), .CMSB(CMSB)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .setn     (setn),
      .fclk     (fclk),
      .push     (push),
      .clear    (clear),
      .wdata    (wdata),
      .empty    (empty),
      .full     (full),
      .underrun (underrun),
      .overrun  (overrun),
      .xst      (xst),
      .nst      (nst),
      .cst      (cst),
      .tx       (tx)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      fclk = 1'b0;
      forever #40 fclk = ~fclk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_push(input logic [7:0] d);
      wdata = d;
      push  = ~push;
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = ~clear;
      repeat (5) @(posedge clk);
      #1;
   endtask

   initial begin
      rstn = 1'b0; setn = 1'b0; push = 1'b0; clear = 1'b0; wdata = '0;
      #23;
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_underrun", 32'(underrun), 0);
      chk("rst_overrun", 32'(overrun), 0);
      chk("rst_xst", 32'(xst), 0);
      chk("rst_nst", 32'(nst), 0);
      chk("rst_cst", 32'(cst), 0);
      chk("rst_tx", 32'(tx), 0);
      #9 rstn = 1'b1;
      repeat (2) @(posedge clk);

      // ch0=0, ch1=+4: densities 1/2 and 3/4 over 64 ticks
      do_push(8'h40);
      chk("t1_nonempty", 32'(empty), 0);
      @(negedge fclk);
      setn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("t1_xst_run", 32'(xst), 2);
      chk("t1_nst_run", 32'(nst), 2);
      chk("t1_popped", 32'(empty), 1);
      ones0 = 0; ones1 = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge fclk);
         ones0 += int'(tx[0]);
         ones1 += int'(tx[1]);
         if (i == 2) begin
            chk("t1_cst3", 32'(cst), 3);
            chk("t1_no_underrun", 32'(underrun), 0);
         end
         if (i == 3) begin
            chk("t1_cst_wrap", 32'(cst), 0);
            chk("t1_underrun", 32'(underrun), 1);
         end
      end
      chk("t1_ones_ch0", 32'(ones0), 32);
      chk("t1_ones_ch1", 32'(ones1), 48);
      chk("t1_tx_last", 32'(tx), 2);

      // setn low mid-RUN
      setn = 1'b0;
      @(posedge clk);
      #1;
      chk("t1_stop_xst", 32'(xst), 0);
      chk("t1_stop_tx", 32'(tx), 0);
      chk("t1_stop_cst", 32'(cst), 0);

      // ch0=-8 (one 1 then zeros), ch1=0
      do_push(8'h08);
      @(negedge fclk);
      setn = 1'b1;
      @(negedge fclk); chk("t2_tick1", 32'(tx), 2'b11);
      @(negedge fclk); chk("t2_tick2", 32'(tx), 2'b00);
      @(negedge fclk); chk("t2_tick3", 32'(tx), 2'b10);
      @(negedge fclk); chk("t2_tick4", 32'(tx), 2'b00);
      setn = 1'b0;
      repeat (2) @(posedge clk);
      do_clear();
      chk("t2_clr_underrun", 32'(underrun), 0);
      chk("t2_clr_empty", 32'(empty), 1);

      // fill A,B,C,D; E dropped
      do_push(8'h4E);
      do_push(8'h22);
      do_push(8'hE4);
      do_push(8'h00);
      chk("t3_full", 32'(full), 1);
      chk("t3_no_overrun", 32'(overrun), 0);
      do_push(8'h80);
      chk("t3_overrun", 32'(overrun), 1);
      chk("t3_still_full", 32'(full), 1);
      @(negedge fclk);
      setn = 1'b1;
      @(negedge fclk); chk("t3_a_tick1", 32'(tx), 2'b11);
      chk("t3_not_full", 32'(full), 0);
      @(negedge fclk); chk("t3_a_tick2", 32'(tx), 2'b00);
      @(negedge fclk); chk("t3_a_tick3", 32'(tx), 2'b10);
      @(negedge fclk); chk("t3_a_tick4", 32'(tx), 2'b11);
      repeat (2) @(negedge fclk);
      setn = 1'b0;
      @(posedge clk);
      #1;
      chk("t3_stop_xst", 32'(xst), 0);
      chk("t3_stop_tx", 32'(tx), 0);
      chk("t3_stop_cst", 32'(cst), 0);
      chk("t3_fifo_kept", 32'(empty), 0);
      setn = 1'b1;
      @(negedge fclk); chk("t3_c_tick1", 32'(tx), 2'b11);
      @(negedge fclk); chk("t3_c_tick2", 32'(tx), 2'b00);
      @(negedge fclk); chk("t3_c_tick3", 32'(tx), 2'b01);
      setn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("t3_d_left", 32'(empty), 0);
      chk("t3_overrun_held", 32'(overrun), 1);
      do_clear();
      chk("t3_clr_empty", 32'(empty), 1);
      chk("t3_clr_full", 32'(full), 0);
      chk("t3_clr_overrun", 32'(overrun), 0);

      // asynchronous reset mid-RUN
      do_push(8'h22);
      do_push(8'h22);
      @(negedge fclk);
      setn = 1'b1;
      @(negedge fclk);
      chk("t4_pre_tx", 32'(tx), 2'b11);
      chk("t4_pre_cst", 32'(cst), 1);
      chk("t4_pre_empty", 32'(empty), 0);
      #12 rstn = 1'b0;
      #2;
      chk("t4_rst_empty", 32'(empty), 1);
      chk("t4_rst_xst", 32'(xst), 0);
      chk("t4_rst_nst", 32'(nst), 0);
      chk("t4_rst_cst", 32'(cst), 0);
      chk("t4_rst_tx", 32'(tx), 0);
      setn = 1'b0; push = 1'b0; clear = 1'b0;
      #20 rstn = 1'b1;
      repeat (2) @(posedge clk);

      // simultaneous push and clear
      do_push(8'h33);
      chk("t5_nonempty", 32'(empty), 0);
      wdata = 8'h55;
      push  = ~push;
      clear = ~clear;
      repeat (5) @(posedge clk);
      #1;
      chk("t5_empty", 32'(empty), 1);
      chk("t5_full", 32'(full), 0);
      setn = 1'b1;
      repeat (3) @(negedge fclk);
      chk("t5_load_wait", 32'(xst), 1);
      chk("t5_load_tx", 32'(tx), 0);
      chk("t5_load_no_underrun", 32'(underrun), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
